fc_layer_engine: RTL and testbench

//  Parametrised fully-connected NN layer engine; Avalon-MM master on the SDRAM bridge.

---
 rtl/fc_layer_pkg.sv | 50 +++++
 rtl/fc_mac.sv | 68 ++++++
 rtl/fc_layer_engine.sv | 231 +++++++++++++++++++++++
 tb/tb_fc_layer_engine.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_layer_pkg.sv
// Shared definitions for the fully-connected layer engine.
// Holds the 8-bit state codes shown on the status LEDs, the word stride and arithmetic helpers.
// The helpers are width-generic and operate on 64-bit signed values (ACC_W must stay <= 63).
package fc_layer_pkg;

  // State codes are fixed so the hex LED readout stays meaningful across builds
  typedef enum logic [7:0] {
    ST_IDLE = 8'h00,
    ST_RD_B = 8'h01,
    ST_WT_B = 8'h02,
    ST_RD_W = 8'h03,
    ST_WT_W = 8'h04,
    ST_RD_X = 8'h05,
    ST_WT_X = 8'h06,
    ST_MAC  = 8'h07,
    ST_WR   = 8'h08,
    ST_NEXT = 8'h09,
    ST_DONE = 8'h0A
  } fc_state_e;

  // Every operand and result is a 16-bit word at a 2-byte stride
  localparam logic [31:0] WORD_STRIDE = 32'd2;

  // Clamp a signed value into the signed range of a w-bit two's complement word
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

  // Optional rectifier: negative values become zero when enabled
  function automatic logic signed [63:0] relu_clamp(input logic signed [63:0] v,
                                                    input logic en);
    return (en && (v < 64'sd0)) ? 64'sd0 : v;
  endfunction

  // Byte address of word idx in an array starting at base (wraps at 32 bits)
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + idx * WORD_STRIDE;
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Signed multiply-accumulate with saturating accumulator and output formatting.
// Latency: acc updates one cycle after clr/load/en; result reflects the value acc is about to take.
// No backpressure: the engine only pulses controls when operands are valid.
module fc_mac
  import fc_layer_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic              en,
  input  logic              relu_en,
  input  logic [DATA_W-1:0] load_val,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W:0]      sum;
  logic signed [ACC_W-1:0]    acc_sat;
  logic signed [ACC_W-1:0]    bias_val;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [63:0]         out_val;

  // Full-width product, guarded sum and saturation back to the accumulator range
  always_comb begin
    prod     = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(b));
    sum      = $signed({acc_q[ACC_W-1], acc_q}) + (ACC_W+1)'(prod);
    acc_sat  = ACC_W'(sat_signed(64'(sum), ACC_W));
    bias_val = ACC_W'($signed(load_val)) <<< FRAC_BITS;
  end

  // Next accumulator value: clear wins over load, load over accumulate
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (load) begin
      acc_d = bias_val;
    end else if (en) begin
      acc_d = acc_sat;
    end
  end

  // Output formatting on the next value so the write word is ready on WR entry
  always_comb begin
    shifted = acc_d >>> FRAC_BITS;
    out_val = relu_clamp(sat_signed(64'(shifted), DATA_W), relu_en);
    result  = out_val[DATA_W-1:0];
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: y[j] = act(b[j] + sum_i W[j][i]*x[i]) over an Avalon-MM master.
// Latency: per input one W read, one x read and one MAC cycle; one write per neuron.
// Backpressure: requests hold address/strobe until waitrequest drops; one read outstanding at a time.
module fc_layer_engine
  import fc_layer_pkg::*;
#(
  parameter int N_IN      = 784,
  parameter int N_OUT     = 200,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40,
  parameter int USE_BIAS  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              relu_en,
  input  logic [31:0]       w_base,
  input  logic [31:0]       x_base,
  input  logic [31:0]       b_base,
  input  logic [31:0]       y_base,
  input  logic              waitrequest,
  input  logic              readdatavalid,
  input  logic [DATA_W-1:0] readdata,
  output logic              chipselect,
  output logic [1:0]        byteenable,
  output logic              read_n,
  output logic              write_n,
  output logic [31:0]       address,
  output logic [DATA_W-1:0] writedata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       status
);

  localparam logic [31:0] LAST_I   = 32'(N_IN - 1);
  localparam logic [31:0] LAST_J   = 32'(N_OUT - 1);
  localparam fc_state_e   FIRST_RD = (USE_BIAS != 0) ? ST_RD_B : ST_RD_W;

  fc_state_e         state_q;
  fc_state_e         state_nxt;
  logic [31:0]       i_q, i_nxt;
  logic [31:0]       j_q, j_nxt;
  logic [31:0]       widx_q, widx_nxt;   // running j*N_IN+i, avoids a multiplier
  logic [31:0]       w_base_q, x_base_q, b_base_q, y_base_q;
  logic [31:0]       w_base_e, x_base_e, b_base_e, y_base_e;
  logic              relu_q;
  logic [DATA_W-1:0] w_q, x_q;
  logic              read_nxt, write_nxt;
  logic [31:0]       addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              mac_clr, mac_load, mac_en;
  logic [DATA_W-1:0] mac_result;

  assign chipselect = 1'b1;
  assign byteenable = 2'b11;
  assign status     = {j_q[15:0], i_q[7:0], state_q};

  // Bases come straight from the ports on the start cycle, from the latched copy afterwards
  assign w_base_e = (state_q == ST_IDLE) ? w_base : w_base_q;
  assign x_base_e = (state_q == ST_IDLE) ? x_base : x_base_q;
  assign b_base_e = (state_q == ST_IDLE) ? b_base : b_base_q;
  assign y_base_e = (state_q == ST_IDLE) ? y_base : y_base_q;

  // Accumulator controls: clear at the start of each neuron, bias load, one MAC per input
  assign mac_clr  = ((state_q == ST_IDLE) || (state_q == ST_NEXT)) && (state_nxt == FIRST_RD);
  assign mac_load = (state_q == ST_WT_B) && readdatavalid;
  assign mac_en   = (state_q == ST_MAC);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and loop-counter logic
  always_comb begin
    state_nxt = state_q;
    i_nxt     = i_q;
    j_nxt     = j_q;
    widx_nxt  = widx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_nxt = FIRST_RD;
          i_nxt     = '0;
          j_nxt     = '0;
          widx_nxt  = '0;
        end
      end
      ST_RD_B: if (!waitrequest)  state_nxt = ST_WT_B;
      ST_WT_B: if (readdatavalid) state_nxt = ST_RD_W;
      ST_RD_W: if (!waitrequest)  state_nxt = ST_WT_W;
      ST_WT_W: if (readdatavalid) state_nxt = ST_RD_X;
      ST_RD_X: if (!waitrequest)  state_nxt = ST_WT_X;
      ST_WT_X: if (readdatavalid) state_nxt = ST_MAC;
      ST_MAC: begin
        // The weight index advances on every MAC, so after a row it already points at the next row
        widx_nxt = widx_q + 32'd1;
        if (i_q < LAST_I) begin
          i_nxt     = i_q + 32'd1;
          state_nxt = ST_RD_W;
        end else begin
          state_nxt = ST_WR;
        end
      end
      ST_WR: if (!waitrequest) state_nxt = ST_NEXT;
      ST_NEXT: begin
        if (j_q < LAST_J) begin
          j_nxt     = j_q + 32'd1;
          i_nxt     = '0;
          state_nxt = FIRST_RD;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: if (!start) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered Avalon outputs, derived from the state being entered
  always_comb begin
    read_nxt  = 1'b0;
    write_nxt = 1'b0;
    addr_nxt  = address;
    wdata_nxt = writedata;
    case (state_nxt)
      ST_RD_B: begin
        read_nxt = 1'b1;
        addr_nxt = word_addr(b_base_e, j_nxt);
      end
      ST_RD_W: begin
        read_nxt = 1'b1;
        addr_nxt = word_addr(w_base_e, widx_nxt);
      end
      ST_RD_X: begin
        read_nxt = 1'b1;
        addr_nxt = word_addr(x_base_e, i_nxt);
      end
      ST_WR: begin
        write_nxt = 1'b1;
        addr_nxt  = word_addr(y_base_e, j_nxt);
        if (state_q != ST_WR) begin
          wdata_nxt = mac_result;
        end
      end
      default: ;
    endcase
  end

  // Registered Avalon strobes, address, write data and handshake flags
  always_ff @(posedge clk) begin
    if (reset) begin
      read_n    <= 1'b1;
      write_n   <= 1'b1;
      address   <= '0;
      writedata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      read_n    <= ~read_nxt;
      write_n   <= ~write_nxt;
      address   <= addr_nxt;
      writedata <= wdata_nxt;
      busy      <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
      done      <= (state_nxt == ST_DONE);
    end
  end

  // Loop counters
  always_ff @(posedge clk) begin
    if (reset) begin
      i_q    <= '0;
      j_q    <= '0;
      widx_q <= '0;
    end else begin
      i_q    <= i_nxt;
      j_q    <= j_nxt;
      widx_q <= widx_nxt;
    end
  end

  // Per-pass configuration latched on an accepted start; operands captured on read data
  always_ff @(posedge clk) begin
    if (reset) begin
      w_base_q <= '0;
      x_base_q <= '0;
      b_base_q <= '0;
      y_base_q <= '0;
      relu_q   <= 1'b0;
      w_q      <= '0;
      x_q      <= '0;
    end else begin
      if ((state_q == ST_IDLE) && start) begin
        w_base_q <= w_base;
        x_base_q <= x_base;
        b_base_q <= b_base;
        y_base_q <= y_base;
        relu_q   <= relu_en;
      end
      if ((state_q == ST_WT_W) && readdatavalid) begin
        w_q <= readdata;
      end
      if ((state_q == ST_WT_X) && readdatavalid) begin
        x_q <= readdata;
      end
    end
  end

  fc_mac #(
    .DATA_W   (DATA_W),
    .FRAC_BITS(FRAC_BITS),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clr     (mac_clr),
    .load    (mac_load),
    .en      (mac_en),
    .relu_en (relu_q),
    .load_val(readdata),
    .a       (w_q),
    .b       (x_q),
    .result  (mac_result)
  );

endmodule

// File: tb/tb_fc_layer_engine.sv
// Self-checking bench for fc_layer_engine with an Avalon memory model and a write scoreboard.
// Expected y words come from a longint reference model and are queued when a layer is loaded.
// The memory model inserts random waitrequest stalls and read latency and checks request stability.
module tb_fc_layer_engine;

  localparam int N_IN      = 4;
  localparam int N_OUT     = 2;
  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;
  localparam int ACC_W     = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        relu_en;
  logic [31:0] w_base, x_base, b_base, y_base;
  logic        waitrequest;
  logic        readdatavalid;
  logic [15:0] readdata;
  logic        chipselect;
  logic [1:0]  byteenable;
  logic        read_n, write_n;
  logic [31:0] address;
  logic [15:0] writedata;
  logic        busy, done;
  logic [31:0] status;

  int errors = 0;
  int checks = 0;
  int max_stall = 0;
  int max_rsp = 0;
  int wr_count = 0;
  int rd_req_cnt = 0;

  logic [15:0]        mem [logic [31:0]];
  logic [47:0]        exp_q [$];
  logic signed [15:0] wv [N_OUT][N_IN];
  logic signed [15:0] xv [N_IN];
  logic signed [15:0] bv [N_OUT];

  always #5 clk = ~clk;

  fc_layer_engine #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS),
    .ACC_W(ACC_W), .USE_BIAS(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .w_base(w_base), .x_base(x_base), .b_base(b_base), .y_base(y_base),
    .waitrequest(waitrequest), .readdatavalid(readdatavalid), .readdata(readdata),
    .chipselect(chipselect), .byteenable(byteenable), .read_n(read_n), .write_n(write_n),
    .address(address), .writedata(writedata), .busy(busy), .done(done), .status(status)
  );

  // Reference: Q8.8 operands, saturating ACC_W accumulator, floor shift, 16-bit saturation, ReLU
  function automatic logic [15:0] model_y(input int j, input bit relu);
    longint acc, lim, r;
    lim = longint'(1) <<< (ACC_W - 1);
    acc = longint'(bv[j]) * 256;
    for (int i = 0; i < N_IN; i++) begin
      acc = acc + longint'(wv[j][i]) * longint'(xv[i]);
      if (acc > lim - 1) acc = lim - 1;
      if (acc < -lim) acc = -lim;
    end
    r = acc >>> FRAC_BITS;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return r[15:0];
  endfunction

  // Avalon slave: stalls, read latency, stability checks and write scoreboard
  initial begin : avalon_slave
    bit          in_req, granted, g_rd, rsp_pending;
    int          stall, rsp_delay;
    logic [31:0] r_addr, g_addr;
    logic        r_rdn, r_wrn;
    logic [15:0] r_dat, g_dat, rsp_data;
    logic [47:0] e;
    in_req = 0; granted = 0; g_rd = 0; rsp_pending = 0;
    waitrequest = 1'b1; readdatavalid = 1'b0; readdata = '0;
    forever begin
      @(posedge clk); #1;
      readdatavalid = 1'b0;
      if (reset === 1'b1) begin
        in_req = 0; granted = 0; rsp_pending = 0; waitrequest = 1'b1;
      end else begin
        if (granted) begin
          granted = 0;
          if (g_rd) begin
            rsp_pending = 1;
            rsp_delay   = $urandom_range(0, max_rsp);
            rsp_data    = mem.exists(g_addr) ? mem[g_addr] : 16'h0000;
          end else begin
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_write got addr=%h data=%h want no write", g_addr, g_dat);
            end else begin
              e = exp_q.pop_front();
              if (g_addr !== e[47:16] || g_dat !== e[15:0]) begin
                errors++;
                $display("FAIL write_word got addr=%h data=%h want addr=%h data=%h",
                         g_addr, g_dat, e[47:16], e[15:0]);
              end
            end
          end
        end
        if (rsp_pending) begin
          if (rsp_delay == 0) begin
            readdatavalid = 1'b1;
            readdata      = rsp_data;
            rsp_pending   = 0;
          end else begin
            rsp_delay--;
          end
        end
        if (read_n === 1'b0 || write_n === 1'b0) begin
          if (!in_req) begin
            in_req = 1;
            stall  = $urandom_range(0, max_stall);
            r_addr = address; r_rdn = read_n; r_wrn = write_n; r_dat = writedata;
            if (read_n === 1'b0) rd_req_cnt++;
          end else begin
            checks++;
            if (address !== r_addr || read_n !== r_rdn || write_n !== r_wrn ||
                (r_wrn === 1'b0 && writedata !== r_dat)) begin
              errors++;
              $display("FAIL stall_stable got addr=%h rd_n=%b wr_n=%b data=%h want addr=%h rd_n=%b wr_n=%b data=%h",
                       address, read_n, write_n, writedata, r_addr, r_rdn, r_wrn, r_dat);
            end
          end
          if (stall > 0) begin
            waitrequest = 1'b1;
            stall--;
          end else begin
            waitrequest = 1'b0;
            granted = 1; in_req = 0;
            g_rd = (r_rdn === 1'b0); g_addr = r_addr; g_dat = r_dat;
          end
        end else begin
          waitrequest = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Fill memory from wv/xv/bv and queue the expected output writes
  task automatic load_layer(input logic [31:0] wb, input logic [31:0] xb,
                            input logic [31:0] bb, input logic [31:0] yb, input bit relu);
    mem.delete();
    exp_q.delete();
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) mem[wb + 32'(2 * (j * N_IN + i))] = wv[j][i];
      mem[bb + 32'(2 * j)] = bv[j];
      exp_q.push_back({yb + 32'(2 * j), model_y(j, relu)});
    end
    for (int i = 0; i < N_IN; i++) mem[xb + 32'(2 * i)] = xv[i];
    w_base = wb; x_base = xb; b_base = bb; y_base = yb; relu_en = relu;
  endtask

  // One full pass: start, wait for done, hold start, release, check completion
  task automatic run_pass(input string name, input int hold, input bit glitch);
    int n;
    wr_count = 0;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
      start = !(glitch && n == 20);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout got done=%b want 1 within %0d cycles", name, done, n);
    end
    checks++;
    if (status[31:16] !== 16'(N_OUT - 1) || status[15:8] !== 8'(N_IN - 1)) begin
      errors++;
      $display("FAIL %s_status_counters got j=%0d i=%0d want j=%0d i=%0d",
               name, status[31:16], status[15:8], N_OUT - 1, N_IN - 1);
    end
    for (int k = 0; k < hold; k++) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_hold got done=%b busy=%b want done=1 busy=0", name, done, busy);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after got done=%b busy=%b want 0 0", name, done, busy);
    end
    checks++;
    if (wr_count != N_OUT) begin
      errors++;
      $display("FAIL %s_write_count got %0d want %0d", name, wr_count, N_OUT);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes got %0d pending want 0", name, exp_q.size());
    end
  endtask

  task automatic set_basic_data();
    wv[0] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    wv[1] = '{16'h0080, 16'hFF80, 16'h0200, 16'h0000};
    xv    = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    bv    = '{16'h0000, 16'h0040};
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; relu_en = 1'b0;
    w_base = '0; x_base = '0; b_base = '0; y_base = '0;
    repeat (3) @(negedge clk);
    checks++; if (read_n !== 1'b1)  begin errors++; $display("FAIL reset_read_n got %b want 1", read_n); end
    checks++; if (write_n !== 1'b1) begin errors++; $display("FAIL reset_write_n got %b want 1", write_n); end
    checks++; if (address !== 32'h0) begin errors++; $display("FAIL reset_address got %h want 0", address); end
    checks++; if (writedata !== 16'h0) begin errors++; $display("FAIL reset_writedata got %h want 0", writedata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (status !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", status); end
    checks++; if (chipselect !== 1'b1) begin errors++; $display("FAIL chipselect got %b want 1", chipselect); end
    checks++; if (byteenable !== 2'b11) begin errors++; $display("FAIL byteenable got %b want 11", byteenable); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    max_stall = 0; max_rsp = 0;
    set_basic_data();
    load_layer(32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000, 1'b0);
    run_pass("basic", 0, 1'b0);
  endtask

  task automatic test_relu();
    max_stall = 1; max_rsp = 1;
    set_basic_data();
    wv[1] = '{16'h0000, 16'h0000, 16'hFF00, 16'h0000};
    bv    = '{16'h0000, 16'h0000};
    load_layer(32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000, 1'b1);
    run_pass("relu_on", 0, 1'b0);
    load_layer(32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000, 1'b0);
    run_pass("relu_off", 0, 1'b0);
  endtask

  task automatic test_saturation();
    max_stall = 0; max_rsp = 1;
    wv[0] = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
    wv[1] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    xv    = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
    bv    = '{16'h0000, 16'h0000};
    load_layer(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 1'b0);
    run_pass("saturation", 0, 1'b0);
  endtask

  task automatic test_stalls();
    max_stall = 5; max_rsp = 3;
    set_basic_data();
    // x array straddles the top of the address space to exercise 32-bit wrap
    load_layer(32'h0000_1000, 32'hFFFF_FFFC, 32'h0000_3000, 32'h0000_4000, 1'b0);
    run_pass("stalls", 0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    int n;
    max_stall = 2; max_rsp = 2;
    set_basic_data();
    load_layer(32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000, 1'b0);
    exp_q.delete();
    rd_req_cnt = 0;
    wr_count = 0;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (rd_req_cnt < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rd_req_cnt < 3) begin
      errors++;
      $display("FAIL midrst_third_read got %0d reads want 3", rd_req_cnt);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (read_n !== 1'b1) begin errors++; $display("FAIL midrst_read_n got %b want 1", read_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (wr_count != 0 || write_n !== 1'b1) begin
      errors++;
      $display("FAIL midrst_no_write got writes=%0d write_n=%b want 0 1", wr_count, write_n);
    end
    load_layer(32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000, 1'b0);
    run_pass("restart", 0, 1'b0);
  endtask

  task automatic test_handshake();
    max_stall = 1; max_rsp = 1;
    set_basic_data();
    load_layer(32'h0000_5000, 32'h0000_6000, 32'h0000_7000, 32'h0000_8000, 1'b0);
    run_pass("handshake", 10, 1'b1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; relu_en = 1'b0;
    w_base = '0; x_base = '0; b_base = '0; y_base = '0;
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_stalls();
    test_reset_mid_run();
    test_handshake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
